// File: rtl/seq_comparator_if.sv
// seq_comparator_if: request/operand/result bundle for seq_comparator.
//   master: drives req, sign_mode, x, y; observes fin, busy and the result.
//   slave : the comparator side.
// Width must match the Width parameter of the attached seq_comparator.
interface seq_comparator_if #(
  parameter int Width = 32
);
  logic             req;
  logic             sign_mode;
  logic [Width-1:0] x;
  logic [Width-1:0] y;
  logic             fin;
  logic             busy;
  logic             bigger;
  logic             equal;
  logic             smaller;

  modport master (
    output req, sign_mode, x, y,
    input  fin, busy, bigger, equal, smaller
  );

  modport slave (
    input  req, sign_mode, x, y,
    output fin, busy, bigger, equal, smaller
  );
endinterface

// File: rtl/seq_comparator.sv
// seq_comparator: chunk-serial magnitude comparator on a 4-phase req/fin
// handshake. Operands are latched on the starting edge and compared MSB
// chunk first, one chunk per clock, stopping at the first differing chunk.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - seq_comparator_if.slave (req, sign_mode, x, y in;
//           fin, busy, bigger, equal, smaller out)
//
// state | meaning
// IDLE  | waiting for req=1 with armed=1
// CMP   | comparing chunk idx of latched operands
// DONE  | result valid on fin/bigger/equal/smaller until req drops
module seq_comparator #(
  parameter int Width      = 32,
  parameter int ChunkWidth = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_comparator_if.slave bus
);

  localparam int NChunk = (Width + ChunkWidth - 1) / ChunkWidth;
  localparam int Ext    = NChunk * ChunkWidth;
  localparam int IdxW   = (NChunk > 1) ? $clog2(NChunk) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMP  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic            armed_q, armed_d;
  logic [IdxW-1:0] idx_q,   idx_d;
  logic [Ext-1:0]  xa_q,    xa_d;
  logic [Ext-1:0]  ya_q,    ya_d;
  logic [2:0]      res_q,   res_d;
  logic            fin_q,   fin_d;
  logic            busy_q,  busy_d;

  logic [Width-1:0]      flip;
  logic [Ext-1:0]        x_sh, y_sh;
  logic [ChunkWidth-1:0] x_chunk, y_chunk;

  always_comb begin
    // Inverting the sign bit of both operands maps two's-complement order
    // onto unsigned order, so the chunk compare stays unsigned.
    flip = '0;
    flip[Width-1] = bus.sign_mode;

    x_sh    = xa_q >> (ChunkWidth * int'(idx_q));
    y_sh    = ya_q >> (ChunkWidth * int'(idx_q));
    x_chunk = x_sh[ChunkWidth-1:0];
    y_chunk = y_sh[ChunkWidth-1:0];

    state_d = state_q;
    armed_d = armed_q;
    idx_d   = idx_q;
    xa_d    = xa_q;
    ya_d    = ya_q;
    res_d   = res_q;

    if (!bus.req) armed_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (bus.req && armed_q) begin
          xa_d    = Ext'(bus.x ^ flip);
          ya_d    = Ext'(bus.y ^ flip);
          idx_d   = IdxW'(NChunk - 1);
          armed_d = 1'b0;
          state_d = CMP;
        end
      end
      CMP: begin
        if (x_chunk > y_chunk) begin
          res_d   = 3'b100;
          state_d = DONE;
        end else if (x_chunk < y_chunk) begin
          res_d   = 3'b001;
          state_d = DONE;
        end else if (idx_q == '0) begin
          res_d   = 3'b010;
          state_d = DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      DONE: begin
        if (!bus.req) begin
          res_d   = 3'b000;
          state_d = IDLE;
        end
      end
      default: begin
        res_d   = 3'b000;
        state_d = IDLE;
      end
    endcase

    // fin/busy come straight from flops so they cannot glitch on state decode.
    fin_d  = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      armed_q <= 1'b0;
      idx_q   <= '0;
      xa_q    <= '0;
      ya_q    <= '0;
      res_q   <= 3'b000;
      fin_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      idx_q   <= idx_d;
      xa_q    <= xa_d;
      ya_q    <= ya_d;
      res_q   <= res_d;
      fin_q   <= fin_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.fin     = fin_q;
  assign bus.busy    = busy_q;
  assign bus.bigger  = res_q[2];
  assign bus.equal   = res_q[1];
  assign bus.smaller = res_q[0];

endmodule

// File: tb/tb_seq_comparator.sv
// tb_seq_comparator: directed bench for seq_comparator with a 32/8 instance
// (dut_a) and a 12/5 instance (dut_b). Expected results are queued when a
// transaction is launched and popped when fin is observed.
module tb_seq_comparator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_comparator_if #(.Width(32)) bus_a ();
  seq_comparator_if #(.Width(12)) bus_b ();

  seq_comparator #(.Width(32), .ChunkWidth(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave)
  );
  seq_comparator #(.Width(12), .ChunkWidth(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [2:0] res;
    int         lat;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit b, input logic r, input logic s,
                       input logic [31:0] xv, input logic [31:0] yv);
    if (!b) begin
      bus_a.req = r; bus_a.sign_mode = s; bus_a.x = xv; bus_a.y = yv;
    end else begin
      bus_b.req = r; bus_b.sign_mode = s; bus_b.x = xv[11:0]; bus_b.y = yv[11:0];
    end
  endtask

  // {fin, busy, bigger, equal, smaller}
  function automatic logic [4:0] outs(input bit b);
    if (!b) return {bus_a.fin, bus_a.busy, bus_a.bigger, bus_a.equal, bus_a.smaller};
    else    return {bus_b.fin, bus_b.busy, bus_b.bigger, bus_b.equal, bus_b.smaller};
  endfunction

  // Launch at a negedge; the following posedge is edge 0. Optionally
  // disturbs x/sign_mode after edge 1 to prove the operands were latched.
  // Returns at posedge+1 with fin observed (or the bound expired).
  task automatic txn(input string tag, input bit b, input logic s,
                     input logic [31:0] xv, input logic [31:0] yv,
                     input logic [2:0] res, input int lat,
                     input bit disturb = 1'b0);
    int n;
    logic [4:0] o;
    exp_t e;
    sb.push_back('{tag, res, lat});
    @(negedge clk);
    drive(b, 1'b1, s, xv, yv);
    @(posedge clk); #1;
    n = 0;
    o = outs(b);
    while (!o[4] && n < 10) begin
      @(posedge clk); #1;
      n++;
      o = outs(b);
      if (disturb && n == 1) drive(b, 1'b1, ~s, 32'hFFFF_FFFF, yv);
    end
    e = sb.pop_front();
    check({e.tag, "_lat"}, n, e.lat);
    check({e.tag, "_res"}, {29'd0, o[2:0]}, {29'd0, e.res});
    check({e.tag, "_busy"}, {31'd0, o[3]}, 32'd1);
  endtask

  // Drop req at posedge+1; outputs must be cleared after the next edge.
  task automatic release_req(input string tag, input bit b);
    if (!b) bus_a.req = 1'b0; else bus_b.req = 1'b0;
    @(posedge clk); #1;
    check({tag, "_rel"}, {27'd0, outs(b)}, 32'd0);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    check("reset_a", {27'd0, outs(1'b0)}, 32'd0);
    check("reset_b", {27'd0, outs(1'b1)}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: four chunks examined
    txn("t1", 1'b0, 1'b0, 32'h1234_5678, 32'h1234_5677, 3'b100, 4);
    release_req("t1", 1'b0);

    // 2: sign mode decides at the top chunk
    txn("t2u", 1'b0, 1'b0, 32'h8000_0000, 32'h0000_0001, 3'b100, 1);
    release_req("t2u", 1'b0);
    txn("t2s", 1'b0, 1'b1, 32'h8000_0000, 32'h0000_0001, 3'b001, 1);
    release_req("t2s", 1'b0);

    // 3: equal, held through 10 extra cycles without retrigger
    txn("t3", 1'b0, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b010, 4);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("t3_hold", {27'd0, outs(1'b0)}, 32'b11010);
    end
    release_req("t3", 1'b0);

    // 4: operand/mode changes during CMP ignored
    txn("t4", 1'b0, 1'b0, 32'd5, 32'd9, 3'b001, 4, 1'b1);
    release_req("t4", 1'b0);

    // 5: async reset mid-CMP, req held through release
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0001, 32'h0000_0002);
    repeat (2) @(posedge clk);
    #2;
    check("t5_busy_pre", {31'd0, bus_a.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_async", {27'd0, outs(1'b0)}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("t5_noarm", {27'd0, outs(1'b0)}, 32'd0);
    end
    @(negedge clk);
    bus_a.req = 1'b0;
    txn("t5", 1'b0, 1'b0, 32'h0000_0001, 32'h0000_0002, 3'b001, 4);
    release_req("t5", 1'b0);

    // 6: 12-bit operands with a 2-bit top chunk
    txn("t6s", 1'b1, 1'b1, 32'h800, 32'h7FF, 3'b001, 1);
    release_req("t6s", 1'b1);
    txn("t6u", 1'b1, 1'b0, 32'h800, 32'h7FF, 3'b100, 1);
    release_req("t6u", 1'b1);
    txn("t6e", 1'b1, 1'b0, 32'hABC, 32'hABC, 3'b010, 3);
    release_req("t6e", 1'b1);

    // back-to-back: new req on the cycle right after release
    txn("t7", 1'b0, 1'b0, 32'h0000_1000, 32'h0000_2000, 3'b001, 3);
    release_req("t7", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
